fft_sequencer: RTL and testbench
================================

# fft_sequencer

Control block for the radix-2 FFT datapath. It runs one shared butterfly unit over an in-place N-point sample memory, stage by stage. For each butterfly it generates the even/odd read and write addresses and the twiddle ROM address. It also drives the butterfly's `read`/`done` handshake and reports completion or a butterfly timeout to the frame controller above it.

## Interface
Parameters:
- `N_POINTS`, 64: FFT length. Must be a power of 2 and at least 4.
- `ADDR_W`, `$clog2(N_POINTS)`: sample memory address width; also the number of stages.
- `TIMEOUT`, 16: maximum number of cycles spent waiting for `bfly_done` before the error path is taken. Must be at least 2.

Ports:
- `clock` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: requests a transform. Sampled only in IDLE.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle pulse when the transform completes.
- `error` out 1: sticky timeout flag. Cleared by an accepted `start` or by `reset`.
- `mem_rd_en` out 1: sample memory read strobe. The memory has 1-cycle read latency.
- `mem_rd_addr_even`, `mem_rd_addr_odd` out `ADDR_W`: read addresses.
- `mem_wr_en` out 1: sample memory write strobe.
- `mem_wr_addr_even`, `mem_wr_addr_odd` out `ADDR_W`: write addresses.
- `twiddle_addr` out `ADDR_W-1`: twiddle ROM index k, for W_N^k.
- `bfly_read` out 1: one-cycle launch pulse to the butterfly.
- `bfly_done` in 1: butterfly result valid.
- `stage` out `ADDR_W`: current stage index.
- `bfly_index` out `ADDR_W-1`: current butterfly index within the stage.

## Operation
The algorithm is decimation-in-time. The loader has already written the input in bit-reversed order; the output is in natural order.

Per-butterfly address math, with s = `stage` and b = `bfly_index`:
- half = 1<<s.
- pos = b & (half-1).
- group = b>>s.
- even = (group<<(s+1)) | pos.
- odd = even + half.
- tw = pos<<(ADDR_W-1-s).

Write addresses equal the read addresses of the same butterfly; the write is in place. They are held in registers captured in READ.

FSM states:
- IDLE: outputs inactive. On `start`=1, go to READ. This transition clears `stage`, `bfly_index`, `error` and the timeout counter.
- READ: `mem_rd_en`=1 for one cycle, with valid read addresses. Next state is LAUNCH.
- LAUNCH: `bfly_read`=1 for one cycle; memory data is valid this cycle. Next state is WAIT.
- WAIT: the timeout counter increments each cycle.
  - If `bfly_done`=1, go to WRITE.
  - Otherwise, if the counter reaches `TIMEOUT`, set `error`=1 and go to IDLE. `done` is not pulsed.
- WRITE: `mem_wr_en`=1 for one cycle. Then advance the counters:
  - If b < N/2-1, increment b.
  - Otherwise set b=0 and increment s.
  - Next state is FINISH after the last butterfly of the last stage, otherwise READ.
- FINISH: `done`=1 for one cycle. Next state is IDLE.

Boundary conditions:
- `start` outside IDLE is ignored.
- `bfly_done` outside WAIT is ignored.
- `start` held high continuously restarts a new transform after each FINISH→IDLE.
- `reset` mid-transform returns to IDLE next edge. All outputs go to 0 and the counters clear; no write or `done` is issued.

## Timing
- Reset values: every output is 0, including `error`, `stage`, `bfly_index` and all addresses.
- All outputs are registered or decoded from state. There are no combinational paths from `bfly_done` or `start` to outputs.
- Butterfly cost is 3 + D cycles, where D ≥ 1 is the number of WAIT cycles, counting the cycle `bfly_done` is seen.
- Full transform, with `start` accepted at cycle 0:
  - READ of the first butterfly is at cycle 1.
  - `done` is at cycle 1 + (N/2)·ADDR_W·(3+D).
  - IDLE is the next cycle.
  - `busy` is high from cycle 1 through the `done` cycle inclusive.
- Timeout: `error` rises on the edge after the `TIMEOUT`-th WAIT cycle, together with the return to IDLE.

## Test plan
- Address walk, N=8, butterfly answers with D=1:
  - s0 b0 → even 0, odd 1, tw 0.
  - s1 b1 → 1/3/2.
  - s1 b2 → 4/6/0.
  - s2 b3 → 3/7/3.
  - Write addresses must equal read addresses for every butterfly.
- Latency, N=8, D=1, `start` at cycle 0 → `done` pulse exactly at cycle 49 and `busy` high for cycles 1–49. Repeat with D=3: `done` at cycle 73.
- Timeout, `TIMEOUT`=16, `bfly_done` never asserted → `error`=1 and IDLE after 16 WAIT cycles, with no `done` and no `mem_wr_en`. A following `start` clears `error`.
- Reset mid-run: assert `reset` during WAIT of s1 b2 → next cycle all outputs are 0 and state is IDLE. A new `start` begins at s0 b0.
- Ignored inputs:
  - `start` pulses during READ, LAUNCH and WAIT do not disturb the sequence.
  - A `bfly_done` pulse in READ does not skip WAIT.
  - `start` tied high yields back-to-back transforms, with exactly one IDLE cycle between `done` and the next READ.

Source files
------------

// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - radix-2 DIT FFT butterfly sequencer
// Walks stage/butterfly counters, issues in-place memory and twiddle addresses, and runs the butterfly handshake.
module fft_sequencer #(
  parameter int N_POINTS = 64,
  parameter int ADDR_W   = $clog2(N_POINTS),
  parameter int TIMEOUT  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr_even,
  output logic [ADDR_W-1:0] mem_rd_addr_odd,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr_even,
  output logic [ADDR_W-1:0] mem_wr_addr_odd,
  output logic [ADDR_W-2:0] twiddle_addr,
  output logic              bfly_read,
  input  logic              bfly_done,
  output logic [ADDR_W-1:0] stage,
  output logic [ADDR_W-2:0] bfly_index
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LAUNCH, S_WAIT, S_WRITE, S_FINISH
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_stage;
  logic [ADDR_W-2:0] r_bfly;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_busy, r_done, r_error;
  logic              r_mem_rd_en, r_mem_wr_en, r_bfly_read;
  logic [ADDR_W-1:0] r_rd_even, r_rd_odd, r_wr_even, r_wr_odd;
  logic [ADDR_W-2:0] r_tw;

  logic              w_last_b, w_last_stage;
  logic [ADDR_W-1:0] w_nxt_stage, w_half, w_pos, w_group, w_even, w_odd;
  logic [ADDR_W-2:0] w_nxt_bfly, w_tw;

  // Addresses are computed for the butterfly about to be read: (0,0) from IDLE, the advanced counters from WRITE.
  always_comb begin
    w_last_b     = &r_bfly;
    w_last_stage = (r_stage == ADDR_W'(ADDR_W - 1));
    w_nxt_stage  = '0;
    w_nxt_bfly   = '0;
    if (r_state == S_WRITE) begin
      w_nxt_bfly  = w_last_b ? '0 : r_bfly + (ADDR_W-1)'(1);
      w_nxt_stage = w_last_b ? r_stage + ADDR_W'(1) : r_stage;
    end
    w_half  = ADDR_W'(1) << w_nxt_stage;
    w_pos   = {1'b0, w_nxt_bfly} & (w_half - ADDR_W'(1));
    w_group = {1'b0, w_nxt_bfly} >> w_nxt_stage;
    w_even  = (w_group << (w_nxt_stage + ADDR_W'(1))) | w_pos;
    w_odd   = w_even + w_half;
    w_tw    = w_pos[ADDR_W-2:0] << (ADDR_W'(ADDR_W - 1) - w_nxt_stage);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_stage     <= '0;
      r_bfly      <= '0;
      r_tmo       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_bfly_read <= 1'b0;
      r_rd_even   <= '0;
      r_rd_odd    <= '0;
      r_wr_even   <= '0;
      r_wr_odd    <= '0;
      r_tw        <= '0;
    end else begin
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_bfly_read <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_READ;
            r_busy      <= 1'b1;
            r_error     <= 1'b0;
            r_stage     <= '0;
            r_bfly      <= '0;
            r_tmo       <= '0;
            r_mem_rd_en <= 1'b1;
            r_rd_even   <= w_even;
            r_rd_odd    <= w_odd;
            r_tw        <= w_tw;
          end
        end
        S_READ: begin
          r_state     <= S_LAUNCH;
          r_bfly_read <= 1'b1;
          r_wr_even   <= r_rd_even;
          r_wr_odd    <= r_rd_odd;
        end
        S_LAUNCH: begin
          r_state <= S_WAIT;
          r_tmo   <= '0;
        end
        S_WAIT: begin
          r_tmo <= r_tmo + TMO_W'(1);
          if (bfly_done) begin
            r_state     <= S_WRITE;
            r_mem_wr_en <= 1'b1;
          end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end
        end
        S_WRITE: begin
          r_stage <= w_nxt_stage;
          r_bfly  <= w_nxt_bfly;
          if (w_last_b && w_last_stage) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
          end else begin
            r_state     <= S_READ;
            r_mem_rd_en <= 1'b1;
            r_rd_even   <= w_even;
            r_rd_odd    <= w_odd;
            r_tw        <= w_tw;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign error            = r_error;
  assign mem_rd_en        = r_mem_rd_en;
  assign mem_rd_addr_even = r_rd_even;
  assign mem_rd_addr_odd  = r_rd_odd;
  assign mem_wr_en        = r_mem_wr_en;
  assign mem_wr_addr_even = r_wr_even;
  assign mem_wr_addr_odd  = r_wr_odd;
  assign twiddle_addr     = r_tw;
  assign bfly_read        = r_bfly_read;
  assign stage            = r_stage;
  assign bfly_index       = r_bfly;

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - randomized self-checking bench for fft_sequencer
`timescale 1ns/1ps
module tb_fft_sequencer;
  localparam int N   = 8;
  localparam int AW  = 3;
  localparam int NB  = (N / 2) * AW;
  localparam int TMO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          bfly_done = 1'b0;
  logic          busy, done, error, mem_rd_en, mem_wr_en, bfly_read;
  logic [AW-1:0] rd_e, rd_o, wr_e, wr_o, stage;
  logic [AW-2:0] tw, bidx;

  int n_checks = 0;
  int n_errors = 0;
  int m_s[NB], m_b[NB], m_even[NB], m_odd[NB], m_tw[NB];
  int o_even[NB], o_odd[NB], o_tw[NB];

  fft_sequencer #(.N_POINTS(N), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error),
    .mem_rd_en(mem_rd_en), .mem_rd_addr_even(rd_e), .mem_rd_addr_odd(rd_o),
    .mem_wr_en(mem_wr_en), .mem_wr_addr_even(wr_e), .mem_wr_addr_odd(wr_o),
    .twiddle_addr(tw), .bfly_read(bfly_read), .bfly_done(bfly_done),
    .stage(stage), .bfly_index(bidx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Butterfly list straight from the DIT index rules, in issue order.
  function automatic void build_model();
    int i;
    int half;
    i = 0;
    for (int s = 0; s < AW; s++) begin
      for (int b = 0; b < N / 2; b++) begin
        half      = 2 ** s;
        m_s[i]    = s;
        m_b[i]    = b;
        m_even[i] = (b / half) * 2 * half + (b % half);
        m_odd[i]  = m_even[i] + half;
        m_tw[i]   = (b % half) * ((N / 2) / half);
        i++;
      end
    end
  endfunction

  task automatic chk_all_zero(input string p);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_done"}, 32'(done), 0);
    chk({p, "_error"}, 32'(error), 0);
    chk({p, "_rd_en"}, 32'(mem_rd_en), 0);
    chk({p, "_wr_en"}, 32'(mem_wr_en), 0);
    chk({p, "_bfly_read"}, 32'(bfly_read), 0);
    chk({p, "_stage"}, 32'(stage), 0);
    chk({p, "_bidx"}, 32'(bidx), 0);
    chk({p, "_rd_e"}, 32'(rd_e), 0);
    chk({p, "_rd_o"}, 32'(rd_o), 0);
    chk({p, "_wr_e"}, 32'(wr_e), 0);
    chk({p, "_wr_o"}, 32'(wr_o), 0);
    chk({p, "_tw"}, 32'(tw), 0);
  endtask

  // dfix=0 picks a random D per butterfly; noise adds stray start/bfly_done pulses.
  task automatic run_xform(input int dfix, input bit noise, input bit hold, output int done_cyc);
    int dd[NB];
    int exp_done, idx, wcnt, cyc, k;
    bit in_wait;
    exp_done = 1;
    for (int i = 0; i < NB; i++) begin
      dd[i] = (dfix > 0) ? dfix : int'($urandom_range(1, 4));
      exp_done += 3 + dd[i];
    end
    idx = 0; wcnt = 0; cyc = 0; in_wait = 0; done_cyc = -1;
    @(negedge clock);
    start = 1'b1;
    while (cyc < 2000 && done_cyc < 0) begin
      @(negedge clock);
      cyc++;
      bfly_done = 1'b0;
      if (!hold) start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("busy", 32'(busy), 1);
      k = (idx > 0 && idx <= NB) ? idx - 1 : 0;
      if (mem_rd_en) begin
        if (idx < NB) begin
          chk("rd_stage", 32'(stage), m_s[idx]);
          chk("rd_bidx", 32'(bidx), m_b[idx]);
          chk("rd_even", 32'(rd_e), m_even[idx]);
          chk("rd_odd", 32'(rd_o), m_odd[idx]);
          chk("rd_tw", 32'(tw), m_tw[idx]);
          o_even[idx] = int'(rd_e);
          o_odd[idx]  = int'(rd_o);
          o_tw[idx]   = int'(tw);
        end
        idx++;
        if (noise) bfly_done = 1'($urandom_range(0, 1));
      end
      if (bfly_read) begin
        in_wait = 1'b1;
        wcnt = 0;
      end else if (in_wait) begin
        wcnt++;
        if (wcnt == dd[k]) begin
          bfly_done = 1'b1;
          in_wait = 1'b0;
        end
      end
      if (mem_wr_en) begin
        chk("wr_even", 32'(wr_e), m_even[k]);
        chk("wr_odd", 32'(wr_o), m_odd[k]);
      end
      if (done) begin
        done_cyc = cyc;
        start = hold;
      end
    end
    chk("done_cyc", done_cyc, exp_done);
    chk("read_count", idx, NB);
    @(negedge clock);
    bfly_done = 1'b0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
  endtask

  initial begin
    int dc, w, rd;
    bit prev_launch;
    build_model();
    repeat (3) @(negedge clock);
    chk_all_zero("rst");
    reset = 1'b0;

    run_xform(1, 1'b0, 1'b0, dc);
    chk("lat_d1", dc, 49);
    chk("s0b0_even", o_even[0], 0);  chk("s0b0_odd", o_odd[0], 1);  chk("s0b0_tw", o_tw[0], 0);
    chk("s1b1_even", o_even[5], 1);  chk("s1b1_odd", o_odd[5], 3);  chk("s1b1_tw", o_tw[5], 2);
    chk("s1b2_even", o_even[6], 4);  chk("s1b2_odd", o_odd[6], 6);  chk("s1b2_tw", o_tw[6], 0);
    chk("s2b3_even", o_even[11], 3); chk("s2b3_odd", o_odd[11], 7); chk("s2b3_tw", o_tw[11], 3);

    run_xform(3, 1'b0, 1'b0, dc);
    chk("lat_d3", dc, 73);
    repeat (4) run_xform(0, 1'b1, 1'b0, dc);

    // Timeout: bfly_done never answers.
    @(negedge clock);
    start = 1'b1;
    w = 0;
    do begin
      @(negedge clock);
      start = 1'b0;
      w++;
    end while (!bfly_read && w < 20);
    chk("tmo_launch", 32'(bfly_read), 1);
    for (int j = 1; j <= TMO; j++) begin
      @(negedge clock);
      chk("tmo_wait_error", 32'(error), 0);
      chk("tmo_wait_wr", 32'(mem_wr_en), 0);
      chk("tmo_wait_done", 32'(done), 0);
      chk("tmo_wait_busy", 32'(busy), 1);
    end
    @(negedge clock);
    chk("tmo_error", 32'(error), 1);
    chk("tmo_idle", 32'(busy), 0);
    chk("tmo_nodone", 32'(done), 0);
    @(negedge clock);
    chk("tmo_sticky", 32'(error), 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("tmo_clear", 32'(error), 0);
    chk("tmo_restart_rd", 32'(mem_rd_en), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    // Reset during WAIT of s1 b2.
    start = 1'b1;
    rd = 0; w = 0; prev_launch = 1'b0;
    while (w < 200) begin
      @(negedge clock);
      w++;
      start = 1'b0;
      bfly_done = prev_launch;
      prev_launch = bfly_read;
      if (mem_rd_en) begin
        rd++;
        if (rd == 7) break;
      end
    end
    chk("mid_rd_count", rd, 7);
    chk("mid_stage", 32'(stage), 1);
    chk("mid_bidx", 32'(bidx), 2);
    bfly_done = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("midrst");
    reset = 1'b0;
    run_xform(1, 1'b0, 1'b0, dc);
    chk("post_rst_lat", dc, 49);

    // start tied high: one IDLE cycle, then the next READ.
    run_xform(1, 1'b0, 1'b1, dc);
    chk("b2b_lat", dc, 49);
    @(negedge clock);
    chk("b2b_read", 32'(mem_rd_en), 1);
    chk("b2b_stage", 32'(stage), 0);
    chk("b2b_bidx", 32'(bidx), 0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
